// File: rtl/haar_stage_sequencer_if.sv
// Sequencer <-> stage table / feature memory / classifier bundle; master = sequencer side.
// No backpressure: the sequencer assumes the table is combinational and memory data lags the read strobe by 1 cycle.
interface haar_stage_sequencer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 16,
   parameter int ADDR_WIDTH = 12,
   parameter int NUM_STAGES = 22
);
   localparam int STAGE_WIDTH = $clog2(NUM_STAGES);

   logic                   i_start;
   logic                   o_busy;
   logic                   o_done;
   logic                   o_face;
   logic [STAGE_WIDTH-1:0] o_stage_reached;
   logic [STAGE_WIDTH-1:0] o_stage_idx;
   logic [ADDR_WIDTH-1:0]  i_stage_count;
   logic [ACC_WIDTH-1:0]   i_stage_threshold;
   logic                   o_feature_rd;
   logic [ADDR_WIDTH-1:0]  o_feature_addr;
   logic                   o_param_load;
   logic [DATA_WIDTH-1:0]  i_haarvalue;

   modport master (
      input  i_start, i_stage_count, i_stage_threshold, i_haarvalue,
      output o_busy, o_done, o_face, o_stage_reached, o_stage_idx,
             o_feature_rd, o_feature_addr, o_param_load
   );

   modport slave (
      output i_start, i_stage_count, i_stage_threshold, i_haarvalue,
      input  o_busy, o_done, o_face, o_stage_reached, o_stage_idx,
             o_feature_rd, o_feature_addr, o_param_load
   );
endinterface

// File: rtl/haar_stage_sequencer.sv
// Haar cascade stage sequencer: walks stages, streams features, accumulates and early-rejects a window.
// Each stage costs N+4 cycles (N features); no backpressure, i_start only honoured in IDLE.
module haar_stage_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 16,
   parameter int ADDR_WIDTH = 12,
   parameter int NUM_STAGES = 22
) (
   input logic                   clk,
   input logic                   reset,
   haar_stage_sequencer_if.master bus
);
   localparam int STAGE_WIDTH = $clog2(NUM_STAGES);
   localparam logic [STAGE_WIDTH-1:0] LAST_STAGE = STAGE_WIDTH'(NUM_STAGES - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_STAGE,
      FEATURE,
      DRAIN,
      COMPARE,
      DONE
   } state_t;

   state_t                 state, next_state;
   logic [STAGE_WIDTH-1:0] stage_idx;
   logic [STAGE_WIDTH-1:0] stage_reached;
   logic [ADDR_WIDTH-1:0]  feat_ptr;
   logic [ADDR_WIDTH-1:0]  remaining;
   logic [ACC_WIDTH-1:0]   threshold;
   logic [ACC_WIDTH-1:0]   acc;
   logic                   drain_cnt;
   logic                   param_load;
   logic                   acc_en;
   logic                   face;
   logic                   feature_rd;
   logic                   busy;
   logic                   done;
   logic                   pass;
   logic                   last_stage;
   logic [ACC_WIDTH-1:0]   haar_ext;

   assign haar_ext   = {{(ACC_WIDTH-DATA_WIDTH){bus.i_haarvalue[DATA_WIDTH-1]}}, bus.i_haarvalue};
   assign pass       = $signed(acc) >= $signed(threshold);
   assign last_stage = (stage_idx == LAST_STAGE);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      feature_rd = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (bus.i_start) next_state = LOAD_STAGE;
         end
         LOAD_STAGE: begin
            next_state = (bus.i_stage_count == '0) ? DRAIN : FEATURE;
         end
         FEATURE: begin
            feature_rd = 1'b1;
            if (remaining == ADDR_WIDTH'(1)) next_state = DRAIN;
         end
         DRAIN: begin
            if (drain_cnt) next_state = COMPARE;
         end
         COMPARE: begin
            next_state = (!pass || last_stage) ? DONE : LOAD_STAGE;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stage_idx     <= '0;
         stage_reached <= '0;
         feat_ptr      <= '0;
         remaining     <= '0;
         threshold     <= '0;
         acc           <= '0;
         drain_cnt     <= 1'b0;
         param_load    <= 1'b0;
         acc_en        <= 1'b0;
         face          <= 1'b0;
      end else begin
         // Two-stage strobe pipeline matches memory read latency plus classifier latency.
         param_load <= feature_rd;
         acc_en     <= param_load;
         if (acc_en) acc <= acc + haar_ext;

         case (state)
            IDLE: begin
               if (bus.i_start) begin
                  stage_idx <= '0;
                  feat_ptr  <= '0;
                  acc       <= '0;
                  face      <= 1'b0;
               end
            end
            LOAD_STAGE: begin
               remaining <= bus.i_stage_count;
               threshold <= bus.i_stage_threshold;
               acc       <= '0;
               drain_cnt <= 1'b0;
            end
            FEATURE: begin
               feat_ptr  <= feat_ptr + 1'b1;
               remaining <= remaining - 1'b1;
            end
            DRAIN: begin
               drain_cnt <= 1'b1;
            end
            COMPARE: begin
               stage_reached <= stage_idx;
               if (!pass)          face      <= 1'b0;
               else if (last_stage) face     <= 1'b1;
               else                stage_idx <= stage_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.o_busy          = busy;
   assign bus.o_done          = done;
   assign bus.o_face          = face;
   assign bus.o_stage_reached = stage_reached;
   assign bus.o_stage_idx     = stage_idx;
   assign bus.o_feature_rd    = feature_rd;
   assign bus.o_feature_addr  = feat_ptr;
   assign bus.o_param_load    = param_load;
endmodule

// File: tb/tb_haar_stage_sequencer.sv
// Directed and randomized windows against a per-stage sum/compare reference model.
module tb_haar_stage_sequencer;
   localparam int NS = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   haar_stage_sequencer_if #(.DATA_WIDTH(8), .ACC_WIDTH(16), .ADDR_WIDTH(12), .NUM_STAGES(NS)) bus ();

   haar_stage_sequencer #(.DATA_WIDTH(8), .ACC_WIDTH(16), .ADDR_WIDTH(12), .NUM_STAGES(NS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [7:0]  mem [4096];
   logic [11:0] cnt_tbl [NS];
   logic [15:0] thr_tbl [NS];
   logic [11:0] rd_addr_q;
   logic [7:0]  hv;

   // External stage table (combinational) and feature memory + classifier (1 + 1 cycle).
   assign bus.i_stage_count     = cnt_tbl[bus.o_stage_idx];
   assign bus.i_stage_threshold = thr_tbl[bus.o_stage_idx];
   assign bus.i_haarvalue       = hv;
   always @(posedge clk) begin
      if (bus.o_feature_rd) rd_addr_q <= bus.o_feature_addr;
      if (bus.o_param_load) hv <= mem[rd_addr_q];
   end

   int addr_q[$];
   always @(negedge clk) if (bus.o_feature_rd === 1'b1) addr_q.push_back(int'(bus.o_feature_addr));

   int n_checks = 0;
   int n_fail   = 0;
   int exp_done, exp_face, exp_reached;
   int exp_addrs[$];

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: a window walks stages, summing the signed words of consecutive
   // addresses mod 2^16, passing when sum >= threshold; each stage costs N+4 cycles.
   task automatic model();
      int ptr = 0;
      int t   = 0;
      exp_addrs.delete();
      exp_face    = 0;
      exp_reached = 0;
      for (int s = 0; s < NS; s++) begin
         int sum = 0;
         logic signed [15:0] w;
         for (int f = 0; f < int'(cnt_tbl[s]); f++) begin
            exp_addrs.push_back(ptr % 4096);
            sum += int'($signed(mem[ptr % 4096]));
            ptr++;
         end
         t += int'(cnt_tbl[s]) + 4;
         exp_reached = s;
         w = 16'(sum);
         if (w < $signed(thr_tbl[s])) begin
            exp_face = 0;
            break;
         end
         if (s == NS - 1) exp_face = 1;
      end
      exp_done = t + 1;
   endtask

   task automatic run_window(string tag, int pulse_at);
      int k;
      int mism;
      model();
      addr_q.delete();
      @(negedge clk);
      bus.i_start = 1'b1;
      k = 0;
      @(negedge clk);
      k = 1;
      bus.i_start = (k == pulse_at);
      check({tag, "_busy"}, 32'(bus.o_busy), 32'd1);
      while (bus.o_done !== 1'b1 && k < 20000) begin
         @(negedge clk);
         k++;
         bus.i_start = (k == pulse_at);
      end
      bus.i_start = 1'b0;
      check({tag, "_done_cycle"}, 32'(k), 32'(exp_done));
      check({tag, "_face"}, 32'(bus.o_face), 32'(exp_face));
      check({tag, "_reached"}, 32'(bus.o_stage_reached), 32'(exp_reached));
      check({tag, "_naddr"}, 32'(addr_q.size()), 32'(exp_addrs.size()));
      mism = 0;
      for (int i = 0; i < exp_addrs.size(); i++)
         if (i >= addr_q.size() || addr_q[i] != exp_addrs[i]) mism++;
      check({tag, "_addr_mism"}, 32'(mism), 32'd0);
      @(negedge clk);
      check({tag, "_done_pulse"}, {30'd0, bus.o_done, bus.o_busy}, 32'd0);
      repeat (3) @(negedge clk);
      check({tag, "_hold"}, {30'd0, bus.o_face, 1'b0} | 32'(bus.o_stage_reached),
            {30'd0, exp_face[0], 1'b0} | 32'(exp_reached));
   endtask

   task automatic check_all_zero(string tag);
      check({tag, "_busy"}, 32'(bus.o_busy), 32'd0);
      check({tag, "_done"}, 32'(bus.o_done), 32'd0);
      check({tag, "_face"}, 32'(bus.o_face), 32'd0);
      check({tag, "_rd"}, 32'(bus.o_feature_rd), 32'd0);
      check({tag, "_pload"}, 32'(bus.o_param_load), 32'd0);
      check({tag, "_addr"}, 32'(bus.o_feature_addr), 32'd0);
      check({tag, "_sidx"}, 32'(bus.o_stage_idx), 32'd0);
      check({tag, "_reached"}, 32'(bus.o_stage_reached), 32'd0);
   endtask

   task automatic setup_s1();
      cnt_tbl[0] = 12'd3; cnt_tbl[1] = 12'd2;
      thr_tbl[0] = 16'd0; thr_tbl[1] = 16'd5;
      mem[0] = 8'd2; mem[1] = 8'hFF; mem[2] = 8'd1; mem[3] = 8'd3; mem[4] = 8'd3;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
      bus.i_start = 1'b0;
      reset = 1'b1;
      setup_s1();
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;

      run_window("s1", -1);

      mem[0] = 8'hFE;
      run_window("s2_reject", -1);

      cnt_tbl[0] = 12'd0; cnt_tbl[1] = 12'd0;
      thr_tbl[0] = 16'd0; thr_tbl[1] = 16'd1;
      run_window("s3_zero_cnt", -1);

      setup_s1();
      run_window("s4_restart_ignored", 3);

      // Reset in the first DRAIN cycle, then a clean window.
      @(negedge clk);
      bus.i_start = 1'b1;
      @(negedge clk);
      bus.i_start = 1'b0;
      repeat (4) @(negedge clk);
      check("s5_in_drain", {30'd0, bus.o_busy, bus.o_feature_rd}, 32'd2);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_all_zero("s5_reset");
      run_window("s5_after_reset", -1);

      for (int i = 0; i < 10; i++) mem[i] = 8'h80;
      cnt_tbl[0] = 12'd10; cnt_tbl[1] = 12'd0;
      thr_tbl[0] = 16'hFB00; thr_tbl[1] = 16'd0;
      run_window("s6_minus128_pass", -1);
      thr_tbl[0] = 16'hFB01;
      run_window("s6_minus128_fail", -1);

      for (int r = 0; r < 6; r++) begin
         for (int s = 0; s < NS; s++) begin
            cnt_tbl[s] = 12'($urandom_range(0, 12));
            thr_tbl[s] = 16'(int'($urandom_range(0, 600)) - 300);
         end
         for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
         run_window($sformatf("rand%0d", r), -1);
      end

      // Long stages: pointer wraps past 4095 and the accumulator wraps mod 2^16.
      for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom_range(100, 127));
      cnt_tbl[0] = 12'd3000; cnt_tbl[1] = 12'd2000;
      thr_tbl[0] = 16'h8000; thr_tbl[1] = 16'h8000;
      run_window("wrap", -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/haar_stage_sequencer.md
HAAR_STAGE_SEQUENCER -- requirements
Module: haar_stage_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of classifier parameter words and of haarvalue.
REQ-002 SHALL have parameter ACC_WIDTH, default 16: width of the stage accumulator and the stage threshold.
REQ-003 SHALL have parameter ADDR_WIDTH, default 12: width of the feature memory address and the per-stage feature count.
REQ-004 SHALL have parameter NUM_STAGES, default 22: number of cascade stages per window; STAGE_WIDTH = clog2(NUM_STAGES).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port i_start, input, 1 bit: begin evaluating one window.
REQ-008 SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-009 SHALL have port o_done, output, 1 bit: one-cycle pulse at the end of evaluation.
REQ-010 SHALL have port o_face, output, 1 bit: window result, 1 when all stages passed.
REQ-011 SHALL have port o_stage_reached, output, STAGE_WIDTH bits: index of the last stage evaluated.
REQ-012 SHALL have port o_stage_idx, output, STAGE_WIDTH bits: stage-table address, read asynchronously by the external table.
REQ-013 SHALL have port i_stage_count, input, ADDR_WIDTH bits: number of features in stage o_stage_idx.
REQ-014 SHALL have port i_stage_threshold, input, ACC_WIDTH bits: signed pass threshold of stage o_stage_idx.
REQ-015 SHALL have port o_feature_rd, output, 1 bit: feature memory read strobe; memory data is valid 1 cycle later.
REQ-016 SHALL have port o_feature_addr, output, ADDR_WIDTH bits: feature memory address.
REQ-017 SHALL have port o_param_load, output, 1 bit: loads the external classifier parameter register (rects, threshold, left/right words) from memory data.
REQ-018 SHALL have port i_haarvalue, input, DATA_WIDTH bits: classifier output, signed two's complement, valid the cycle after o_param_load.

Function
REQ-019 SHALL implement states IDLE, LOAD_STAGE, FEATURE, DRAIN, COMPARE, DONE.
REQ-020 IDLE SHALL go to LOAD_STAGE when i_start=1, clearing the stage index, feature pointer, accumulator and o_face.
REQ-021 i_start SHALL be ignored in every state except IDLE.
REQ-022 LOAD_STAGE (1 cycle) SHALL latch i_stage_count into a remaining-feature counter and i_stage_threshold into a register, clear the accumulator, and go to FEATURE, or go to DRAIN when the count is 0.
REQ-023 FEATURE SHALL assert o_feature_rd with o_feature_addr = feature pointer every cycle, increment the pointer and decrement the counter, and go to DRAIN after the last feature (N cycles for N features).
REQ-024 The feature pointer SHALL run continuously across stages, never resetting between stages of one window, and SHALL wrap modulo 2^ADDR_WIDTH.
REQ-025 o_param_load SHALL equal o_feature_rd delayed 1 cycle; an accumulate-enable SHALL equal o_param_load delayed 1 cycle.
REQ-026 When accumulate-enable is high, the accumulator SHALL add i_haarvalue sign-extended to ACC_WIDTH, wrapping modulo 2^ACC_WIDTH.
REQ-027 DRAIN SHALL last exactly 2 cycles, then go to COMPARE.
REQ-028 COMPARE (1 cycle) SHALL evaluate pass = (accumulator >= threshold), signed; o_stage_reached <= stage index.
REQ-029 On pass with stage index < NUM_STAGES-1, COMPARE SHALL increment the stage index and go to LOAD_STAGE.
REQ-030 On pass at stage NUM_STAGES-1, COMPARE SHALL set o_face=1 and go to DONE.
REQ-031 On fail, COMPARE SHALL set o_face=0 and go to DONE (early reject).
REQ-032 DONE (1 cycle) SHALL assert o_done, then return to IDLE.
REQ-033 o_face and o_stage_reached SHALL hold their values until the next accepted i_start.
REQ-034 Each stage SHALL take exactly N+4 cycles.
REQ-035 o_stage_idx SHALL equal the stage index register.

Reset
REQ-036 reset SHALL take precedence over every other input, including mid-operation.
REQ-037 On reset the state SHALL be IDLE, with o_busy, o_done, o_face, o_feature_rd, o_param_load and accumulate-enable all 0.
REQ-038 On reset o_feature_addr, o_stage_idx, o_stage_reached and the accumulator SHALL be 0.
REQ-039 No accumulation SHALL occur on the cycle after reset deasserts.

Verification
REQ-040 Scenario 1: NUM_STAGES=2, counts 3/2, thresholds 0/5, haarvalues 2,-1,1 then 3,3, start at cycle 0 -> o_done at cycle 14, o_face=1, o_stage_reached=1, addresses 0..4.
REQ-041 Scenario 2: same setup with stage-0 haarvalues -2,-1,1 -> reject after COMPARE; o_done at cycle 8, o_face=0, o_stage_reached=0, no address 3 issued.
REQ-042 Scenario 3: stage count 0 with threshold 0 -> pass; with threshold 1 -> fail; stage takes 4 cycles.
REQ-043 Scenario 4: i_start pulsed during FEATURE -> ignored, and the result matches Scenario 1.
REQ-044 Scenario 5: reset asserted in DRAIN -> next cycle IDLE with all outputs 0; a following start reproduces the Scenario 1 result.
REQ-045 Scenario 6: haarvalue 8'h80 (-128) ten times, threshold -1280 -> accumulator reads -1280 and the stage passes (exercises sign extension and the >= boundary).
